aging_dispatcher: RTL and testbench
===================================

Name: aging_dispatcher

Overview:
- Consumer side of the aging arbiter grant interface.
- Samples the arbiter's valid/selection and pops one entry from the granted show-ahead queue.
- Forwards that entry downstream over a valid/ready handshake, then pulses update so the arbiter ages its counters.
- Waits out the arbiter's registered-selection latency before taking the next grant; sits between the per-core request queues and the memory-side AXI adapter.

Parameters:
- NUMBER_OF_QUEUES, 4, number of request queues and arbiter inputs; must be ≥2.
- DATA_WIDTH, 64, width of one queued entry.
- SETTLE_CYCLES, 3, cycles to wait after an update pulse before arb_selection is trusted again; range 1..15.
- BURST_LEN, 4, maximum entries per grant; used only with MEMOREDF_BURST_EN; range 1..255.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- arb_valid  in  1  arbiter reports at least one non-empty queue.
- arb_selection  in  $clog2(NUMBER_OF_QUEUES)  granted queue index.
- arb_update  out  1  one-cycle pulse: the grant has been consumed.
- queue_empty  in  NUMBER_OF_QUEUES  per-queue empty flags.
- queue_data  in  NUMBER_OF_QUEUES*DATA_WIDTH  per-queue head entry (show-ahead); queue q occupies bits [q*DATA_WIDTH +: DATA_WIDTH].
- queue_pop  out  NUMBER_OF_QUEUES  one-hot pop strobe.
- m_valid  out  1  downstream entry valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  entry payload.
- m_queue_id  out  $clog2(NUMBER_OF_QUEUES)  source queue of m_data.

Behaviour:
- Reset (reset==0, sampled on a clock edge):
  - state=IDLE; arb_update=0, queue_pop=0, m_valid=0, m_data=0, m_queue_id=0.
  - Settle counter=0; latched index=0.
  - Reset mid-transfer drops the held entry. No update is issued for it.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE:
  - If arb_valid==1 and queue_empty[arb_selection]==0: latch sel=arb_selection, go to FETCH.
  - If arb_valid==1 but the selected queue is empty (stale grant race): stay in IDLE; no pop, no update.
- FETCH (1 cycle):
  - queue_pop[sel]=1 and all other pop bits 0.
  - Capture queue_data[sel] into m_data and sel into m_queue_id, then go to SEND.
- SEND:
  - m_valid=1; m_data and m_queue_id are held stable while m_ready==0.
  - On m_valid&&m_ready: m_valid=0 next cycle, go to UPDATE.
- UPDATE (1 cycle): arb_update=1, load counter=SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - arb_update=0; counter decrements once per cycle.
  - When counter reaches 0, return to IDLE. arb_selection is ignored throughout SETTLE.
- Latency from a qualifying IDLE sample at cycle t:
  - pop at t+1; m_valid at t+2.
  - If m_ready is high, update at t+3.
  - Next grant is sampled no earlier than t+4+SETTLE_CYCLES.
- arb_update is never high for more than one consecutive cycle. At most one queue_pop bit is high per cycle, and only in FETCH.
- Queue index width: $clog2(NUMBER_OF_QUEUES). The settle counter is 4 bits and holds no state beyond SETTLE.

Optional Feature:
- MEMOREDF_BURST_EN defined:
  - An 8-bit served counter is cleared on entry to FETCH from IDLE and incremented on each handshake.
  - After a SEND handshake: if served<BURST_LEN and queue_empty[sel]==0, go to FETCH on the same sel. Otherwise go to UPDATE.
  - Exactly one arb_update pulse is issued per grant, whatever the burst length.
- Undefined: exactly one entry per grant; BURST_LEN is ignored and the served counter is not synthesized.

Test Plan:
- Single grant: queue 2 non-empty with head 0xA5, arb_selection=2, m_ready=1 → queue_pop=4'b0100 for one cycle, m_data=0xA5 with m_queue_id=2, one arb_update pulse, next IDLE sample 3 cycles later.
- Backpressure: m_ready=0 for 5 cycles during SEND → m_valid stays 1 and m_data is stable for 5 cycles; arb_update only after the handshake.
- Stale grant: arb_valid=1, arb_selection=1, queue_empty=4'b0010 → no pop, no update, FSM stays IDLE.
- Reset mid-SEND: reset=0 for one cycle → m_valid=0 and all outputs 0 the next cycle; no arb_update issued.
- Settle window: arb_selection toggles 0→3 during SETTLE with SETTLE_CYCLES=3 → latched sel is the value sampled in IDLE only.
- Burst (MEMOREDF_BURST_EN, BURST_LEN=4): queue 0 holds 6 entries → 4 pops and 4 handshakes, then a single arb_update pulse.

Source files
------------

// File: rtl/aging_dispatcher.sv
// aging_dispatcher: consumer side of the aging arbiter grant interface.
// Takes one grant, pops the granted show-ahead queue, forwards the entry over
// a valid/ready handshake, pulses arb_update, then waits SETTLE_CYCLES before
// trusting arb_selection again.
// Optional feature: define MEMOREDF_BURST_EN to serve up to BURST_LEN entries
// from the same queue per grant (still a single arb_update per grant).
module aging_dispatcher #(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned SETTLE_CYCLES    = 3,
    parameter int unsigned BURST_LEN        = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   arb_valid,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]    arb_selection,
    output logic                                   arb_update,
    input  logic [NUMBER_OF_QUEUES-1:0]            queue_empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] queue_data,
    output logic [NUMBER_OF_QUEUES-1:0]            queue_pop,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]    m_queue_id
);

    localparam int unsigned IDX_W = $clog2(NUMBER_OF_QUEUES);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SRV_W = 8;

    // Elaboration-time parameter range checks
    if (NUMBER_OF_QUEUES < 2) begin : g_chk_nq
        $error("aging_dispatcher: NUMBER_OF_QUEUES must be >= 2");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_chk_settle
        $error("aging_dispatcher: SETTLE_CYCLES must be in 1..15");
    end
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_chk_burst
        $error("aging_dispatcher: BURST_LEN must be in 1..255");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SEND   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sel;
    logic [CNT_W-1:0]   settle_cnt;

    logic               grant_ok_c;
    logic               more_c;
    logic [DATA_WIDTH-1:0] head_sel_c;

    // One-hot pop strobe for a queue index
    function automatic logic [NUMBER_OF_QUEUES-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUMBER_OF_QUEUES'(1) << idx;
    endfunction

    // A grant qualifies only if the selected queue really holds an entry
    assign grant_ok_c = arb_valid && !queue_empty[arb_selection];

    // Head entry of the latched queue
    assign head_sel_c = queue_data[32'(sel) * DATA_WIDTH +: DATA_WIDTH];

`ifdef MEMOREDF_BURST_EN
    logic [SRV_W-1:0] served;
    logic [SRV_W-1:0] served_inc_c;

    assign served_inc_c = served + SRV_W'(1);
    // Keep draining the same queue while the burst budget lasts and data remains
    assign more_c = (32'(served_inc_c) < BURST_LEN) && !queue_empty[sel];
`else
    assign more_c = 1'b0;
`endif

    // Dispatcher FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sel        <= '0;
            settle_cnt <= '0;
            arb_update <= 1'b0;
            queue_pop  <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_queue_id <= '0;
`ifdef MEMOREDF_BURST_EN
            served     <= '0;
`endif
        end else begin
            arb_update <= 1'b0;
            queue_pop  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (grant_ok_c) begin
                        sel       <= arb_selection;
                        queue_pop <= onehot(arb_selection);
                        state     <= ST_FETCH;
`ifdef MEMOREDF_BURST_EN
                        served    <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    // Show-ahead head is still the popped entry at this edge
                    m_data     <= head_sel_c;
                    m_queue_id <= sel;
                    m_valid    <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
`ifdef MEMOREDF_BURST_EN
                        served  <= served_inc_c;
`endif
                        if (more_c) begin
                            queue_pop <= onehot(sel);
                            state     <= ST_FETCH;
                        end else begin
                            arb_update <= 1'b1;
                            state      <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    settle_cnt <= CNT_W'(SETTLE_CYCLES);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Arbiter selection is not looked at until the count expires
                    if (settle_cnt <= CNT_W'(1)) begin
                        settle_cnt <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    settle_cnt <= '0;
                    m_valid    <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aging_dispatcher.sv
// tb_aging_dispatcher: scoreboard bench for aging_dispatcher with directed
// scenarios followed by randomized traffic against a timing-level reference.
`timescale 1ns/1ps
module tb_aging_dispatcher;

    localparam int NQ     = 4;
    localparam int DW     = 64;
    localparam int SETTLE = 3;
    localparam int BL     = 4;
    localparam int IW     = $clog2(NQ);
`ifdef MEMOREDF_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               arb_valid;
    logic [IW-1:0]      arb_selection;
    logic               arb_update;
    logic [NQ-1:0]      queue_empty;
    logic [NQ*DW-1:0]   queue_data;
    logic [NQ-1:0]      queue_pop;
    logic               m_valid;
    logic               m_ready;
    logic [DW-1:0]      m_data;
    logic [IW-1:0]      m_queue_id;

    always #5 clock = ~clock;

    aging_dispatcher #(
        .NUMBER_OF_QUEUES (NQ),
        .DATA_WIDTH       (DW),
        .SETTLE_CYCLES    (SETTLE),
        .BURST_LEN        (BL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .arb_valid     (arb_valid),
        .arb_selection (arb_selection),
        .arb_update    (arb_update),
        .queue_empty   (queue_empty),
        .queue_data    (queue_data),
        .queue_pop     (queue_pop),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_queue_id    (m_queue_id)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
    } exp_t;

    logic [DW-1:0] qm [NQ][$];
    exp_t          exp_q [$];
    logic [NQ-1:0] pop_seen = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: when things are expected to happen, in cycle numbers
    bit            sending = 1'b0;
    int            pop_at  = -1;
    int            val_at  = -1;
    int            upd_at  = -1;
    int            free_at = 0;
    int            rst_at  = -10;
    int            served  = 0;
    int            cur_id  = 0;
    logic [DW-1:0] cur_d   = '0;

    // External queues pop on the edge where queue_pop is high
    always @(posedge clock) pop_seen <= queue_pop;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_queues();
        for (int q = 0; q < NQ; q++) begin
            queue_empty[q] = (qm[q].size() == 0);
            queue_data[q*DW +: DW] = (qm[q].size() != 0) ? qm[q][0] : '0;
        end
    endtask

    // One clock: apply queue pops, drive inputs, check outputs, advance model
    task automatic step(input bit rst_n, input bit av, input int sel, input bit rdy);
        logic [NQ-1:0] ep;
        exp_t          e;
        @(negedge clock);
        cyc++;
        for (int q = 0; q < NQ; q++) begin
            if (pop_seen[q]) begin
                if (qm[q].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_of_empty cycle=%0d queue=%0d", cyc, q);
                end else begin
                    void'(qm[q].pop_front());
                end
            end
        end
        reset         = rst_n;
        arb_valid     = av;
        arb_selection = IW'(sel);
        m_ready       = rdy;
        drive_queues();

        if (cyc > 1) begin
            ep = (cyc == pop_at) ? (NQ'(1) << cur_id) : '0;
            check("queue_pop", queue_pop, ep);
            check("arb_update", arb_update, (cyc == upd_at));
            check("m_valid", m_valid, (sending && cyc >= val_at));
            if (sending && cyc >= val_at) begin
                check("m_data_held", m_data, cur_d);
                check("m_queue_id_held", m_queue_id, cur_id);
            end
            if (cyc == rst_at + 1) begin
                check("reset_m_data", m_data, '0);
                check("reset_m_queue_id", m_queue_id, '0);
            end
        end

        if (!rst_n) begin
            if (sending) void'(exp_q.pop_back());
            sending = 1'b0;
            pop_at  = -1;
            upd_at  = -1;
            free_at = cyc + 1;
            rst_at  = cyc;
        end else if (sending && cyc >= val_at && rdy) begin
            served++;
            if (BURST && served < BL && qm[cur_id].size() != 0) begin
                pop_at = cyc + 1;
                val_at = cyc + 2;
                cur_d  = qm[cur_id][0];
                e.id = IW'(cur_id);
                e.d  = cur_d;
                exp_q.push_back(e);
            end else begin
                sending = 1'b0;
                upd_at  = cyc + 1;
                free_at = cyc + 2 + SETTLE;
            end
        end else if (!sending && cyc >= free_at && av && qm[sel].size() != 0) begin
            sending = 1'b1;
            cur_id  = sel;
            served  = 0;
            pop_at  = cyc + 1;
            val_at  = cyc + 2;
            cur_d   = qm[sel][0];
            e.id = IW'(cur_id);
            e.d  = cur_d;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every accepted downstream beat must match the next expected entry
    always begin
        exp_t e;
        @(negedge clock);
        #1;
        if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_handshake cycle=%0d got=%h want=none", cyc, m_data);
            end else begin
                e = exp_q.pop_front();
                check("hs_m_data", m_data, e.d);
                check("hs_m_queue_id", m_queue_id, e.id);
            end
        end
    end

    initial begin
        reset         = 1'b0;
        arb_valid     = 1'b0;
        arb_selection = '0;
        m_ready       = 1'b0;
        drive_queues();

        repeat (3) step(0, 0, 0, 0);

        // Single grant from queue 2
        qm[2].push_back(64'hA5);
        step(1, 1, 2, 1);
        repeat (10) step(1, 0, 0, 1);

        // Stale grant: queue 1 empty, others not
        qm[0].push_back(64'h1111_0000_0000_0001);
        qm[2].push_back(64'h2222_0000_0000_0002);
        qm[3].push_back(64'h3333_0000_0000_0003);
        repeat (4) step(1, 1, 1, 1);

        // Backpressure on a grant from queue 0
        step(1, 1, 0, 0);
        repeat (7) step(1, 0, 0, 0);
        repeat (8) step(1, 0, 0, 1);

        // Selection toggling during the settle window
        step(1, 1, 3, 1);
        for (int i = 0; i < 12; i++) step(1, 1, (i % 2) ? 3 : 0, 1);
        repeat (10) step(1, 0, 0, 1);

        // Reset while an entry is being offered
        qm[1].push_back(64'hDEAD_BEEF_0000_0001);
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 1);

        // Deep queue 0: burst when enabled, single entry otherwise
        for (int i = 0; i < 6; i++) qm[0].push_back(64'hB000_0000_0000_0000 | 64'(i));
        step(1, 1, 0, 1);
        repeat (30) step(1, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(3) == 0) begin
                int q;
                q = int'($urandom_range(NQ - 1));
                if (qm[q].size() < 8) qm[q].push_back({$urandom, $urandom});
            end
            step(($urandom_range(299) != 0), ($urandom_range(3) != 0),
                 int'($urandom_range(NQ - 1)), ($urandom_range(2) != 0));
        end

        // Drain outstanding work
        repeat (60) step(1, 0, 0, 1);
        check("scoreboard_drained", 64'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
